// File: rtl/imem_loader.sv
// Program loader for the 16 x 32 instruction memory: assembles big-endian bytes
// into words, writes them to addresses 0..NUM_WORDS-1 and holds the CPU in reset meanwhile.
module imem_loader #(
    parameter int NUM_WORDS = 16,
    parameter int ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              loading,
    output logic              done,
    output logic              cpu_hold
);

    // state | meaning
    // IDLE  | waiting for start after reset
    // RECV  | collecting the four bytes of the current word
    // WRITE | one-cycle write strobe for the assembled word
    // DONE  | load complete, CPU released; start triggers a reload
    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);

    state_t              state_q;
    logic [ADDR_W-1:0]   word_cnt_q;
    logic [1:0]          byte_cnt_q;
    logic [23:0]         shreg_q;
    logic                byte_ready_q;
    logic                we_q;
    logic [ADDR_W-1:0]   waddr_q;
    logic [31:0]         wdata_q;
    logic                loading_q;
    logic                done_q;
    logic                hold_q;

    // Only the three older bytes need storing; the fourth is taken straight from byte_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            word_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            shreg_q      <= '0;
            byte_ready_q <= 1'b0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            loading_q    <= 1'b0;
            done_q       <= 1'b0;
            hold_q       <= 1'b1;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q      <= RECV;
                        word_cnt_q   <= '0;
                        byte_cnt_q   <= '0;
                        byte_ready_q <= 1'b1;
                        loading_q    <= 1'b1;
                        done_q       <= 1'b0;
                        hold_q       <= 1'b1;
                    end
                end
                RECV: begin
                    if (byte_valid) begin
                        shreg_q <= {shreg_q[15:0], byte_data};
                        if (byte_cnt_q == 2'd3) begin
                            state_q      <= WRITE;
                            byte_cnt_q   <= '0;
                            byte_ready_q <= 1'b0;
                            we_q         <= 1'b1;
                            waddr_q      <= word_cnt_q;
                            wdata_q      <= {shreg_q, byte_data};
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    if (word_cnt_q == LAST_WORD) begin
                        state_q   <= DONE;
                        loading_q <= 1'b0;
                        done_q    <= 1'b1;
                        hold_q    <= 1'b0;
                    end else begin
                        state_q      <= RECV;
                        word_cnt_q   <= word_cnt_q + 1'b1;
                        byte_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign byte_ready = byte_ready_q;
    assign imem_we    = we_q;
    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;
    assign loading    = loading_q;
    assign done       = done_q;
    assign cpu_hold   = hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the driver predicts writes from the accepted byte
// stream, separate monitors pop and compare whenever a write strobe appears.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready, imem_we, loading, done, cpu_hold;
    logic [3:0]  imem_waddr;
    logic [31:0] imem_wdata;

    logic        s1 = 1'b0;
    logic        v1 = 1'b0;
    logic [7:0]  d1 = 8'h00;
    logic        r1, we1, l1, dn1, h1;
    logic [3:0]  a1;
    logic [31:0] w1;

    always #5 clk = ~clk;

    imem_loader #(.NUM_WORDS(16), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .loading(loading),
        .done(done), .cpu_hold(cpu_hold));

    imem_loader #(.NUM_WORDS(1), .ADDR_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1), .byte_valid(v1),
        .byte_data(d1), .byte_ready(r1), .imem_we(we1),
        .imem_waddr(a1), .imem_wdata(w1), .loading(l1),
        .done(dn1), .cpu_hold(h1));

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int last_we = 0;
    bit chk_spacing = 1'b0;
    bit done_prev   = 1'b0;
    logic [35:0] sb0[$];
    logic [35:0] sb1[$];
    logic [7:0]  stim[64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [35:0] e;
        if (rst_n && imem_we) begin
            if (sb0.size() == 0) begin
                check("unexpected_write", 32'(imem_waddr), 32'hxxxx_xxxx);
            end else begin
                e = sb0.pop_front();
                check("waddr", 32'(imem_waddr), 32'(e[35:32]));
                check("wdata", imem_wdata, e[31:0]);
                if (chk_spacing && e[35:32] != 4'd0)
                    check("write_spacing", 32'(cyc - last_we), 32'd5);
            end
            last_we = cyc;
        end
        if (rst_n && done && !done_prev) begin
            check("done_latency", 32'(cyc - last_we), 32'd1);
            check("hold_in_done", 32'(cpu_hold), 32'd0);
        end
        done_prev = done;
    end

    always @(negedge clk) begin
        logic [35:0] e;
        if (rst_n && we1) begin
            if (sb1.size() == 0) begin
                check("unexpected_write1", 32'(a1), 32'hxxxx_xxxx);
            end else begin
                e = sb1.pop_front();
                check("waddr1", 32'(a1), 32'(e[35:32]));
                check("wdata1", w1, e[31:0]);
            end
        end
    end

    // Drive a load of n bytes from stim; expected writes come from every 4 accepted bytes.
    task automatic load(input int n, input bit rnd, input int stall_at, input int start_at);
        int i = 0;
        int stall = 0;
        int guard = 0;
        @(negedge clk);
        start = 1'b1; byte_valid = 1'b1; byte_data = stim[0];
        check("ready_before_start", 32'(byte_ready), 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("ready_after_start", 32'(byte_ready), 32'd1);
        check("loading_after_start", 32'(loading), 32'd1);
        check("done_after_start", 32'(done), 32'd0);
        check("hold_while_loading", 32'(cpu_hold), 32'd1);
        while (i < n && guard < 3000) begin
            start = (i == start_at);
            if (stall > 0) begin
                byte_valid = 1'b0;
                stall--;
            end else if (rnd && $urandom_range(0, 3) == 0) begin
                byte_valid = 1'b0;
            end else begin
                byte_valid = 1'b1;
                byte_data  = stim[i];
            end
            if (byte_valid && byte_ready) begin
                i++;
                if (i % 4 == 0)
                    sb0.push_back({4'(i / 4 - 1), stim[i-4], stim[i-3], stim[i-2], stim[i-1]});
                if (i == stall_at) stall = 3;
            end
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        byte_valid = 1'b0;
        if (guard >= 3000) check("byte_stream_timeout", 32'(i), 32'(n));
        if (n == 64) begin
            guard = 0;
            while (!done && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            check("done_reached", 32'(done), 32'd1);
            check("hold_released", 32'(cpu_hold), 32'd0);
            check("all_writes_seen", 32'(sb0.size()), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] b1 [4];
        int g;
        b1 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

        repeat (3) @(negedge clk);
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_waddr", 32'(imem_waddr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_loading", 32'(loading), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 64; k++) stim[k] = 8'(k);
        chk_spacing = 1'b1;
        load(64, 1'b0, -1, -1);
        chk_spacing = 1'b0;

        load(64, 1'b0, 23, -1);

        for (int k = 0; k < 64; k++) stim[k] = 8'($urandom);
        load(64, 1'b1, -1, -1);

        for (int k = 0; k < 64; k++) stim[k] = 8'($urandom);
        load(10, 1'b0, -1, -1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_byte_ready", 32'(byte_ready), 32'd0);
        check("midrst_we", 32'(imem_we), 32'd0);
        check("midrst_waddr", 32'(imem_waddr), 32'd0);
        check("midrst_wdata", imem_wdata, 32'd0);
        check("midrst_loading", 32'(loading), 32'd0);
        check("midrst_hold", 32'(cpu_hold), 32'd1);
        check("midrst_pending", 32'(sb0.size()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        for (int k = 0; k < 64; k++) stim[k] = 8'(k);
        load(64, 1'b0, -1, -1);

        for (int k = 0; k < 64; k++) stim[k] = 8'($urandom);
        load(64, 1'b1, -1, 13);

        for (int k = 0; k < 64; k++) stim[k] = 8'hFF;
        load(64, 1'b0, -1, -1);

        sb1.push_back({4'd0, 32'hDEADBEEF});
        @(negedge clk);
        s1 = 1'b1;
        @(negedge clk);
        s1 = 1'b0;
        check("n1_ready_after_start", 32'(r1), 32'd1);
        for (int j = 0; j < 4; j++) begin
            v1 = 1'b1;
            d1 = b1[j];
            g = 0;
            while (!r1 && g < 10) begin
                @(negedge clk);
                g++;
            end
            @(negedge clk);
        end
        v1 = 1'b0;
        g = 0;
        while (!dn1 && g < 10) begin
            @(negedge clk);
            g++;
        end
        check("n1_done", 32'(dn1), 32'd1);
        check("n1_hold", 32'(h1), 32'd0);
        check("n1_all_writes_seen", 32'(sb1.size()), 32'd0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
